// File: rtl/am2957x_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | am2957x_fifo : DEPTH-entry clocked elastic buffer with inverting tristate  |
// |                head output, status and sticky over/underflow flags.        |
// |                Optional macro AM2957X_FALLTHRU_EN: d-to-y path when empty. |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module am2957x_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int INVERT = 1,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] d,
    input  logic             ld,
    input  logic             rd,
    input  logic             oe_,
    output logic [WIDTH-1:0] y,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             ovf,
    output logic             unf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef AM2957X_FALLTHRU_EN
    localparam bit FALLTHRU = 1'b1;
`else
    localparam bit FALLTHRU = 1'b0;
`endif

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             wr_en, rd_en;
    logic [WIDTH-1:0] head;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;

    always_comb begin
        wr_en   = ld && (!full || rd);
        rd_en   = rd && !empty;
        ovf_d   = ovf_q | (ld && full && !rd);
        unf_d   = unf_q | (rd && empty);
        // Fall-through consumes the word on the bus: no store, no underflow
        if (FALLTHRU && empty && ld && rd) begin
            wr_en = 1'b0;
            unf_d = unf_q;
        end
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        if (rd_en) rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (wr_en) mem_q[wptr_q] <= d;
        end
    end

    always_comb begin
        head = mem_q[rptr_q];
        if (FALLTHRU && empty) head = d;
    end

    assign y = oe_ ? {WIDTH{1'bz}} : ((INVERT != 0) ? ~head : head);

endmodule
`default_nettype wire
